xaui_rx_reset_seq: RTL and testbench

XAUI_RX_RESET_SEQ -- requirements
Module: xaui_rx_reset_seq

---
 rtl/xaui_rx_reset_seq.sv | 110 +++++++++++
 tb/tb_xaui_rx_reset_seq.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xaui_rx_reset_seq.sv
// XAUI receive-side reset sequencer: watches lane sync and alignment, pulses MGT RX resets
// on failure, then waits out a holdoff before looking at the link again.
module xaui_rx_reset_seq #(
    parameter int unsigned NLANES    = 4,
    parameter int unsigned WAIT_BITS = 24,
    parameter int unsigned STRETCH   = 15,
    parameter int unsigned CNT_BITS  = 8,
    parameter int unsigned PER_LANE  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                soft_reset,
    input  logic                enable,
    input  logic [NLANES-1:0]   lane_sync,
    input  logic                align_ok,
    output logic [NLANES-1:0]   mgt_rx_reset,
    output logic                link_up,
    output logic [CNT_BITS-1:0] retry_count,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        StLook    = 2'd0,
        StReset   = 2'd1,
        StHoldoff = 2'd2,
        StUp      = 2'd3
    } state_e;

    localparam logic [7:0] StretchLoad = 8'(STRETCH);

    state_e               st;
    logic [7:0]           stretch_cnt;
    logic [WAIT_BITS-1:0] wait_cnt;
    logic [NLANES-1:0]    mask;
    logic [NLANES-1:0]    entry_mask;
    logic                 good;

    assign good  = (&lane_sync) & align_ok;
    assign state = st;

    // Only the lanes that lost sync are reset; an alignment-only failure hits every lane.
    always_comb begin
        entry_mask = '1;
        if (PER_LANE != 0 && lane_sync != '1) begin
            entry_mask = ~lane_sync;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st           <= StLook;
            mgt_rx_reset <= '0;
            link_up      <= 1'b0;
            retry_count  <= '0;
            stretch_cnt  <= '0;
            wait_cnt     <= '0;
            mask         <= '0;
        end else if (soft_reset) begin
            st           <= StLook;
            mgt_rx_reset <= '0;
            link_up      <= 1'b0;
            retry_count  <= '0;
            stretch_cnt  <= '0;
            wait_cnt     <= '0;
        end else if (!enable) begin
            st           <= StLook;
            mgt_rx_reset <= '0;
            link_up      <= 1'b0;
            stretch_cnt  <= '0;
        end else begin
            unique case (st)
                StLook, StUp: begin
                    if (good) begin
                        st      <= StUp;
                        link_up <= 1'b1;
                    end else begin
                        st           <= StReset;
                        link_up      <= 1'b0;
                        mask         <= entry_mask;
                        mgt_rx_reset <= entry_mask;
                        stretch_cnt  <= StretchLoad;
                        if (retry_count != '1) begin
                            retry_count <= retry_count + 1'b1;
                        end
                    end
                end
                StReset: begin
                    if (stretch_cnt <= 8'd1) begin
                        st           <= StHoldoff;
                        mgt_rx_reset <= '0;
                        stretch_cnt  <= '0;
                        wait_cnt     <= '1;
                    end else begin
                        stretch_cnt  <= stretch_cnt - 1'b1;
                        mgt_rx_reset <= mask;
                    end
                end
                StHoldoff: begin
                    // Count reaches zero inside HOLDOFF, so the state spans 2^WAIT_BITS cycles.
                    if (wait_cnt == '0) begin
                        st <= StLook;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xaui_rx_reset_seq.sv
// Bench for xaui_rx_reset_seq: directed scenarios plus randomized traffic against a
// cycle-counting reference model, with per-lane and all-lane instances side by side.
module tb_xaui_rx_reset_seq;

    localparam int NL   = 4;
    localparam int WB   = 4;
    localparam int ST   = 3;
    localparam int CB   = 3;
    localparam int HOLD = 2 ** WB;
    localparam int SAT  = 2 ** CB - 1;

    localparam int LOOK = 0;
    localparam int RST  = 1;
    localparam int HOF  = 2;
    localparam int UP   = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          soft_reset = 1'b0;
    logic          enable = 1'b0;
    logic [NL-1:0] lane_sync = '0;
    logic          align_ok = 1'b0;

    logic [NL-1:0] mgt_rx_reset, a_mgt_rx_reset;
    logic          link_up, a_link_up;
    logic [CB-1:0] retry_count, a_retry_count;
    logic [1:0]    state, a_state;

    int errors = 0;
    int checks = 0;

    int            m_state = LOOK;
    int            m_left = 0;
    int            m_retry = 0;
    logic [NL-1:0] m_rst = '0;
    logic [NL-1:0] m_rst_all = '0;

    xaui_rx_reset_seq #(
        .NLANES(NL), .WAIT_BITS(WB), .STRETCH(ST), .CNT_BITS(CB), .PER_LANE(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .soft_reset(soft_reset), .enable(enable),
        .lane_sync(lane_sync), .align_ok(align_ok), .mgt_rx_reset(mgt_rx_reset),
        .link_up(link_up), .retry_count(retry_count), .state(state)
    );

    xaui_rx_reset_seq #(
        .NLANES(NL), .WAIT_BITS(WB), .STRETCH(ST), .CNT_BITS(CB), .PER_LANE(0)
    ) dut_all (
        .clk(clk), .reset_n(reset_n), .soft_reset(soft_reset), .enable(enable),
        .lane_sync(lane_sync), .align_ok(align_ok), .mgt_rx_reset(a_mgt_rx_reset),
        .link_up(a_link_up), .retry_count(a_retry_count), .state(a_state)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        m_state = LOOK; m_left = 0; m_retry = 0; m_rst = '0; m_rst_all = '0;
    endtask

    // Reference: phase plus cycles-remaining in that phase.
    task automatic model_step();
        bit good;
        good = (&lane_sync) && align_ok;
        if (!reset_n || soft_reset) begin
            model_clear();
        end else if (!enable) begin
            m_state = LOOK; m_rst = '0; m_rst_all = '0;
        end else if (m_state == LOOK || m_state == UP) begin
            if (good) begin
                m_state = UP;
            end else begin
                m_state   = RST;
                m_left    = ST;
                m_retry   = (m_retry < SAT) ? m_retry + 1 : SAT;
                m_rst     = (lane_sync == 4'hf) ? 4'hf : ~lane_sync;
                m_rst_all = 4'hf;
            end
        end else if (m_state == RST) begin
            m_left--;
            if (m_left == 0) begin
                m_state = HOF; m_left = HOLD; m_rst = '0; m_rst_all = '0;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_state = LOOK;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Run until LOOK, counting pulse and holdoff cycles; bounded.
    task automatic ride_out(input logic [NL-1:0] mask, input bit scramble,
                            output int nrst, output int nrst_all, output int nhold);
        nrst = 0; nrst_all = 0; nhold = 0;
        for (int i = 0; i < 60 && state != 2'd0; i++) begin
            if (state == 2'd1 && mgt_rx_reset == mask) nrst++;
            if (a_state == 2'd1 && a_mgt_rx_reset == 4'hf) nrst_all++;
            if (state == 2'd2) nhold++;
            if (scramble) begin
                lane_sync = 4'($urandom);
                align_ok  = 1'($urandom);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        enable = 1'b1; lane_sync = 4'hf; align_ok = 1'b1;
        tick(); tick();
        checks++;
        if ({state, link_up, retry_count, mgt_rx_reset, a_mgt_rx_reset} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got st=%0d up=%0b rc=%0d rst=%b/%b want all zero",
                     state, link_up, retry_count, mgt_rx_reset, a_mgt_rx_reset);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_link_up();
        int bad;
        tick();
        checks++;
        if (state !== 2'd3 || link_up !== 1'b1 || retry_count !== 3'd0) begin
            errors++;
            $display("FAIL link_up: got st=%0d up=%0b rc=%0d want st=3 up=1 rc=0",
                     state, link_up, retry_count);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mgt_rx_reset !== '0 || state !== 2'd3) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL link_hold: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_per_lane();
        int nr, na, nh;
        lane_sync = 4'b1011;
        tick();
        lane_sync = 4'hf;
        checks++;
        if (state !== 2'd1 || mgt_rx_reset !== 4'b0100 || a_mgt_rx_reset !== 4'hf
            || retry_count !== 3'd1 || link_up !== 1'b0) begin
            errors++;
            $display("FAIL per_lane_entry: got st=%0d rst=%b all=%b rc=%0d up=%0b want 1 0100 1111 1 0",
                     state, mgt_rx_reset, a_mgt_rx_reset, retry_count, link_up);
        end
        ride_out(4'b0100, 1'b1, nr, na, nh);
        checks++;
        if (nr != ST || na != ST || nh != HOLD || state !== 2'd0 || retry_count !== 3'd1) begin
            errors++;
            $display("FAIL per_lane_seq: got rst=%0d all=%0d hold=%0d st=%0d rc=%0d want 3 3 16 0 1",
                     nr, na, nh, state, retry_count);
        end
        lane_sync = 4'hf; align_ok = 1'b1;
        tick();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL relook_up: got st=%0d want 3", state);
        end
    endtask

    task automatic test_all_lanes();
        int nr, na, nh;
        align_ok = 1'b0;
        tick();
        align_ok = 1'b1;
        checks++;
        if (mgt_rx_reset !== 4'hf || a_mgt_rx_reset !== 4'hf || retry_count !== 3'd2) begin
            errors++;
            $display("FAIL align_entry: got rst=%b all=%b rc=%0d want 1111 1111 2",
                     mgt_rx_reset, a_mgt_rx_reset, retry_count);
        end
        ride_out(4'hf, 1'b0, nr, na, nh);
        checks++;
        if (nr != ST || na != ST || nh != HOLD) begin
            errors++;
            $display("FAIL align_seq: got rst=%0d all=%0d hold=%0d want 3 3 16", nr, na, nh);
        end
        tick();
        enable = 1'b0; lane_sync = 4'h0;
        tick();
        checks++;
        if (state !== 2'd0 || retry_count !== 3'd2 || mgt_rx_reset !== '0 || link_up !== 1'b0) begin
            errors++;
            $display("FAIL enable_fall_bad: got st=%0d rc=%0d rst=%b up=%0b want 0 2 0000 0",
                     state, retry_count, mgt_rx_reset, link_up);
        end
        tick();
        checks++;
        if (state !== 2'd0 || mgt_rx_reset !== '0) begin
            errors++;
            $display("FAIL disabled_look: got st=%0d rst=%b want 0 0000", state, mgt_rx_reset);
        end
    endtask

    task automatic test_saturate();
        int nr, na, nh;
        logic [CB-1:0] exp;
        enable = 1'b1; soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        checks++;
        if (state !== 2'd0 || retry_count !== 3'd0) begin
            errors++;
            $display("FAIL soft_clear: got st=%0d rc=%0d want 0 0", state, retry_count);
        end
        lane_sync = 4'h0; align_ok = 1'b0;
        for (int k = 0; k < 9; k++) begin
            tick();
            exp = 3'((k + 1 > SAT) ? SAT : k + 1);
            checks++;
            if (retry_count !== exp || mgt_rx_reset !== 4'hf) begin
                errors++;
                $display("FAIL saturate_%0d: got rc=%0d rst=%b want %0d 1111",
                         k, retry_count, mgt_rx_reset, exp);
            end
            ride_out(4'hf, 1'b0, nr, na, nh);
        end
    endtask

    task automatic test_enable_abort();
        tick(); tick();
        checks++;
        if (state !== 2'd1 || mgt_rx_reset !== 4'hf) begin
            errors++;
            $display("FAIL abort_pre: got st=%0d rst=%b want 1 1111", state, mgt_rx_reset);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || mgt_rx_reset !== '0 || retry_count !== 3'd7) begin
            errors++;
            $display("FAIL abort: got st=%0d rst=%b rc=%0d want 0 0000 7",
                     state, mgt_rx_reset, retry_count);
        end
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0; enable = 1'b1;
        checks++;
        if (state !== 2'd0 || retry_count !== 3'd0) begin
            errors++;
            $display("FAIL abort_soft: got st=%0d rc=%0d want 0 0", state, retry_count);
        end
    endtask

    task automatic test_async_reset();
        repeat (9) tick();
        checks++;
        if (state !== 2'd2 || retry_count !== 3'd1) begin
            errors++;
            $display("FAIL async_pre: got st=%0d rc=%0d want 2 1", state, retry_count);
        end
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if ({state, link_up, retry_count, mgt_rx_reset, a_state} !== '0) begin
            errors++;
            $display("FAIL async_reset: got st=%0d up=%0b rc=%0d rst=%b want all zero",
                     state, link_up, retry_count, mgt_rx_reset);
        end
        tick();
        reset_n = 1'b1; lane_sync = 4'hf; align_ok = 1'b1;
        tick();
        checks++;
        if (state !== 2'd3 || link_up !== 1'b1 || retry_count !== 3'd0) begin
            errors++;
            $display("FAIL after_reset: got st=%0d up=%0b rc=%0d want 3 1 0",
                     state, link_up, retry_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            enable     = ($urandom_range(0, 31) != 0);
            soft_reset = ($urandom_range(0, 127) == 0);
            lane_sync  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hf;
            align_ok   = ($urandom_range(0, 7) != 0);
            tick();
            checks++;
            if (state !== 2'(m_state) || link_up !== (m_state == UP)
                || retry_count !== 3'(m_retry)) begin
                errors++;
                $display("FAIL rand_ctrl cyc %0d: got st=%0d up=%0b rc=%0d want %0d %0b %0d",
                         c, state, link_up, retry_count, m_state, m_state == UP, m_retry);
            end
            checks++;
            if (mgt_rx_reset !== m_rst || a_mgt_rx_reset !== m_rst_all) begin
                errors++;
                $display("FAIL rand_rst cyc %0d: got %b/%b want %b/%b",
                         c, mgt_rx_reset, a_mgt_rx_reset, m_rst, m_rst_all);
            end
        end
    endtask

    initial begin
        test_reset();
        test_link_up();
        test_per_lane();
        test_all_lanes();
        test_saturate();
        test_enable_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
